bmd_tx_arbiter: RTL and testbench

//  Shares the single TRN transmit interface (trn_t*) of the endpoint between NUM_REQ TLP sources
//  (completion engine, FOFB DMA write engine, MSI/readback source). Grants one requester per TLP,

---
 rtl/bmd_tx_pkg.sv | 17 +
 rtl/bmd_rr_picker.sv | 36 +++
 rtl/bmd_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_bmd_tx_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bmd_tx_pkg.sv
// Shared constants for the BMD transmit arbiter: core buffer classes and FSM encoding.
package bmd_tx_pkg;

  localparam logic [1:0] BUF_NP   = 2'd0;
  localparam logic [1:0] BUF_P    = 2'd1;
  localparam logic [1:0] BUF_CPL  = 2'd2;
  localparam logic [1:0] BUF_RSVD = 2'd3;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    XFER     = 2'd2
  } state_t;

endpackage

// File: rtl/bmd_rr_picker.sv
// Combinational rotate-priority picker: the first eligible requester after ptr wins.
module bmd_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDXW    = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDXW-1:0]    winner_idx
);

  localparam int CW = IDXW + 1;

  logic [CW-1:0] cand;
  logic          found;

  // scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ), take the first eligible
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      cand = (cand >= CW'(NUM_REQ)) ? cand - CW'(NUM_REQ) : cand;
      if (!found && eligible[cand[IDXW-1:0]]) begin
        winner[cand[IDXW-1:0]] = 1'b1;
        winner_idx             = cand[IDXW-1:0];
        found                  = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/bmd_tx_arbiter.sv
// Arbitrates the single TRN transmit interface between NUM_REQ TLP sources, one TLP per grant,
// gated on core buffer availability, with SOF timeout and core-discontinue handling.
module bmd_tx_arbiter
  import bmd_tx_pkg::*;
#(
  parameter int INTERFACE_WIDTH = 64,
  parameter int NUM_REQ         = 3,
  parameter int PRIO0_STRICT    = 1,
  parameter int SOF_TIMEOUT     = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [2*NUM_REQ-1:0]            req_type_i,
  input  logic [NUM_REQ*INTERFACE_WIDTH-1:0]     req_td_i,
  input  logic [NUM_REQ*INTERFACE_WIDTH/8-1:0]   req_trem_n_i,
  input  logic [NUM_REQ-1:0]              req_tsof_n_i,
  input  logic [NUM_REQ-1:0]              req_teof_n_i,
  input  logic [NUM_REQ-1:0]              req_tsrc_rdy_n_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              req_tdst_rdy_n_o,
  output logic [NUM_REQ-1:0]              req_abort_o,
  output logic [INTERFACE_WIDTH-1:0]      trn_td,
  output logic [INTERFACE_WIDTH/8-1:0]    trn_trem_n,
  output logic                            trn_tsof_n,
  output logic                            trn_teof_n,
  output logic                            trn_tsrc_rdy_n,
  output logic                            trn_tsrc_dsc_n,
  input  logic                            trn_tdst_rdy_n,
  input  logic                            trn_tdst_dsc_n,
  input  logic [5:0]                      trn_tbuf_av
);

  localparam int IW   = INTERFACE_WIDTH;
  localparam int RW   = INTERFACE_WIDTH / 8;
  localparam int IDXW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_s, abort_r, abort_s, eligible_s, pick_s;
  logic [IDXW-1:0]    ptr_r, ptr_s, idx_r, idx_s, pick_idx_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               active_s, beat_s, sel_sof_n_s, sel_eof_n_s, sel_rdy_n_s;

  // an invalid class can never be granted; tbuf_av is only consulted here
  always_comb begin
    eligible_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      eligible_s[k] = req_i[k] && (req_type_i[2*k +: 2] != BUF_RSVD)
                      && trn_tbuf_av[{1'b0, req_type_i[2*k +: 2]}];
    end
  end

  bmd_rr_picker #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_picker (
    .eligible   (eligible_s),
    .ptr        (ptr_r),
    .winner     (pick_s),
    .winner_idx (pick_idx_s)
  );

  assign active_s    = (state_r == WAIT_SOF) || (state_r == XFER);
  assign sel_sof_n_s = req_tsof_n_i[idx_r];
  assign sel_eof_n_s = req_teof_n_i[idx_r];
  assign sel_rdy_n_s = req_tsrc_rdy_n_i[idx_r];
  assign beat_s      = active_s && !sel_rdy_n_s && !trn_tdst_rdy_n;

  // the mux is forced to idle values outside a grant so no stray source reaches the core
  assign trn_td           = active_s ? req_td_i[int'(idx_r)*IW +: IW] : '0;
  assign trn_trem_n       = active_s ? req_trem_n_i[int'(idx_r)*RW +: RW] : '0;
  assign trn_tsof_n       = active_s ? sel_sof_n_s : 1'b1;
  assign trn_teof_n       = active_s ? sel_eof_n_s : 1'b1;
  assign trn_tsrc_rdy_n   = active_s ? sel_rdy_n_s : 1'b1;
  assign trn_tsrc_dsc_n   = 1'b1;
  assign req_tdst_rdy_n_o = active_s ? (~gnt_r | {NUM_REQ{trn_tdst_rdy_n}}) : '1;
  assign gnt_o            = gnt_r;
  assign req_abort_o      = abort_r;

  // next-state, grant, pointer and SOF timeout; discontinue outranks EOF acceptance
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    idx_s   = idx_r;
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    abort_s = '0;
    case (state_r)
      IDLE: begin
        if (|eligible_s) begin
          state_s = WAIT_SOF;
          cnt_s   = CNT_W'(SOF_TIMEOUT);
          if ((PRIO0_STRICT != 0) && eligible_s[0]) begin
            gnt_s = ONE_HOT0;
            idx_s = '0;
          end else begin
            gnt_s = pick_s;
            idx_s = pick_idx_s;
            ptr_s = pick_idx_s;
          end
        end else begin
          gnt_s = '0;
        end
      end
      WAIT_SOF: begin
        if (!trn_tdst_dsc_n) begin
          abort_s = gnt_r;
          gnt_s   = '0;
          state_s = IDLE;
        end else if (beat_s && !sel_sof_n_s) begin
          state_s = sel_eof_n_s ? XFER : IDLE;
          gnt_s   = sel_eof_n_s ? gnt_r : '0;
        end else if (cnt_r == '0) begin
          abort_s = gnt_r;
          gnt_s   = '0;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      XFER: begin
        if (!trn_tdst_dsc_n) begin
          abort_s = gnt_r;
          gnt_s   = '0;
          state_s = IDLE;
        end else if (beat_s && !sel_eof_n_s) begin
          gnt_s   = '0;
          state_s = IDLE;
        end else begin
          state_s = XFER;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = '0;
      end
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      idx_r   <= '0;
      ptr_r   <= IDXW'(NUM_REQ - 1);
      cnt_r   <= '0;
      abort_r <= '0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      idx_r   <= idx_s;
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
      abort_r <= abort_s;
    end
  end

endmodule

// File: tb/tb_bmd_tx_arbiter.sv
// Directed bench for bmd_tx_arbiter: a strict-priority instance plus a round-robin instance on shared inputs.
module tb_bmd_tx_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   req;
  logic [5:0]   req_type;
  logic [191:0] td;
  logic [23:0]  trem;
  logic [2:0]   sof_n, eof_n, src_rdy_n;
  logic         dst_rdy_n, dst_dsc_n;
  logic [5:0]   tbuf_av;

  logic [2:0]  gnt, tdst_o, abort;
  logic [63:0] o_td;
  logic [7:0]  o_trem;
  logic        o_sof, o_eof, o_rdy, o_dsc;

  logic [2:0]  r_gnt, r_tdst_o, r_abort;
  logic [63:0] r_td;
  logic [7:0]  r_trem;
  logic        r_sof, r_eof, r_rdy, r_dsc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bmd_tx_arbiter #(.INTERFACE_WIDTH(64), .NUM_REQ(3), .PRIO0_STRICT(1), .SOF_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_type_i(req_type), .req_td_i(td),
    .req_trem_n_i(trem), .req_tsof_n_i(sof_n), .req_teof_n_i(eof_n), .req_tsrc_rdy_n_i(src_rdy_n),
    .gnt_o(gnt), .req_tdst_rdy_n_o(tdst_o), .req_abort_o(abort), .trn_td(o_td),
    .trn_trem_n(o_trem), .trn_tsof_n(o_sof), .trn_teof_n(o_eof), .trn_tsrc_rdy_n(o_rdy),
    .trn_tsrc_dsc_n(o_dsc), .trn_tdst_rdy_n(dst_rdy_n), .trn_tdst_dsc_n(dst_dsc_n),
    .trn_tbuf_av(tbuf_av)
  );

  bmd_tx_arbiter #(.INTERFACE_WIDTH(64), .NUM_REQ(3), .PRIO0_STRICT(0), .SOF_TIMEOUT(15)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_type_i(req_type), .req_td_i(td),
    .req_trem_n_i(trem), .req_tsof_n_i(sof_n), .req_teof_n_i(eof_n), .req_tsrc_rdy_n_i(src_rdy_n),
    .gnt_o(r_gnt), .req_tdst_rdy_n_o(r_tdst_o), .req_abort_o(r_abort), .trn_td(r_td),
    .trn_trem_n(r_trem), .trn_tsof_n(r_sof), .trn_teof_n(r_eof), .trn_tsrc_rdy_n(r_rdy),
    .trn_tsrc_dsc_n(r_dsc), .trn_tdst_rdy_n(dst_rdy_n), .trn_tdst_dsc_n(dst_dsc_n),
    .trn_tbuf_av(tbuf_av)
  );

  task automatic idle_src();
    src_rdy_n = 3'b111;
    sof_n     = 3'b111;
    eof_n     = 3'b111;
  endtask

  task automatic drive(input int k, input bit sof, input bit eof, input logic [63:0] d);
    idle_src();
    src_rdy_n[k]      = 1'b0;
    sof_n[k]          = ~sof;
    eof_n[k]          = ~eof;
    td[k*64 +: 64]    = d;
    trem[k*8 +: 8]    = 8'h00;
  endtask

  // holds reset for two cycles with default stimulus, releases it on a falling edge
  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 3'b000;
    req_type  = 6'b010101;
    td        = '0;
    trem      = '0;
    dst_rdy_n = 1'b0;
    dst_dsc_n = 1'b1;
    tbuf_av   = 6'b111111;
    idle_src();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n     = 1'b0;
    req       = 3'b111;
    req_type  = 6'b010101;
    td        = {3{64'hA5A5_5A5A_0F0F_F0F0}};
    trem      = 24'hFFFFFF;
    dst_rdy_n = 1'b0;
    dst_dsc_n = 1'b1;
    tbuf_av   = 6'b111111;
    src_rdy_n = 3'b000;
    sof_n     = 3'b000;
    eof_n     = 3'b000;
    repeat (2) @(negedge clk);
    total++; if (gnt !== 3'b000) begin $display("FAIL rst_gnt got=%b want=000", gnt); bad++; end
    total++; if (abort !== 3'b000) begin $display("FAIL rst_abort got=%b want=000", abort); bad++; end
    total++; if (tdst_o !== 3'b111) begin $display("FAIL rst_tdst got=%b want=111", tdst_o); bad++; end
    total++; if ({o_rdy, o_sof, o_eof, o_dsc} !== 4'b1111) begin
      $display("FAIL rst_ctl got=%b want=1111", {o_rdy, o_sof, o_eof, o_dsc}); bad++; end
    total++; if ({o_td, o_trem} !== 72'h0) begin $display("FAIL rst_data got=%h want=0", {o_td, o_trem}); bad++; end
    idle_src();
    rst_n = 1'b1;
    #1;
    total++; if (gnt !== 3'b000) begin $display("FAIL rst_release_gnt got=%b want=000", gnt); bad++; end
    @(negedge clk);
    total++; if (gnt !== 3'b001) begin $display("FAIL first_gnt got=%b want=001", gnt); bad++; end
    total++; if (tdst_o !== 3'b110) begin $display("FAIL first_tdst got=%b want=110", tdst_o); bad++; end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_g [0:10];
    logic [63:0] d;
    bit          b;
    int          k;
    exp_g = '{3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000,
              3'b010, 3'b010, 3'b000, 3'b100, 3'b100};
    b = 1'b0;
    do_reset();
    req = 3'b110;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      total++; if (r_gnt !== exp_g[c]) begin $display("FAIL rr_gnt[%0d] got=%b want=%b", c, r_gnt, exp_g[c]); bad++; end
      if (r_gnt == 3'b010 || r_gnt == 3'b100) begin
        k = r_gnt[1] ? 1 : 2;
        d = {32'hC0DE_0000 + 32'(c), 32'(k)};
        drive(k, !b, b, d);
        b = !b;
        #1;
        total++; if (r_td !== d) begin $display("FAIL rr_td[%0d] got=%h want=%h", c, r_td, d); bad++; end
      end else begin
        idle_src();
      end
    end
    req = 3'b000;
    idle_src();
  endtask

  task automatic test_buf_av();
    do_reset();
    req     = 3'b010;
    tbuf_av = 6'b111101;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++; if (gnt !== 3'b000) begin $display("FAIL bufav_hold[%0d] got=%b want=000", c, gnt); bad++; end
    end
    tbuf_av = 6'b111111;
    @(negedge clk);
    total++; if (gnt !== 3'b010) begin $display("FAIL bufav_gnt got=%b want=010", gnt); bad++; end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 3'b100;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      total++; if (gnt !== 3'b100) begin $display("FAIL to_gnt[%0d] got=%b want=100", c, gnt); bad++; end
      total++; if (abort !== 3'b000) begin $display("FAIL to_early[%0d] got=%b want=000", c, abort); bad++; end
    end
    @(negedge clk);
    total++; if (abort !== 3'b100) begin $display("FAIL to_abort got=%b want=100", abort); bad++; end
    total++; if (gnt !== 3'b000) begin $display("FAIL to_drop got=%b want=000", gnt); bad++; end
    @(negedge clk);
    total++; if (abort !== 3'b000) begin $display("FAIL to_pulse got=%b want=000", abort); bad++; end
    req = 3'b000;
  endtask

  task automatic test_discontinue();
    do_reset();
    req = 3'b001;
    @(negedge clk);
    total++; if (gnt !== 3'b001) begin $display("FAIL dsc_gnt got=%b want=001", gnt); bad++; end
    drive(0, 1'b1, 1'b0, 64'h1111);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'h2222);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'h3333);
    dst_dsc_n = 1'b0;
    #1;
    total++; if (o_td !== 64'h3333) begin $display("FAIL dsc_td got=%h want=3333", o_td); bad++; end
    @(negedge clk);
    total++; if (abort !== 3'b001) begin $display("FAIL dsc_abort got=%b want=001", abort); bad++; end
    total++; if (gnt !== 3'b000) begin $display("FAIL dsc_drop got=%b want=000", gnt); bad++; end
    total++; if (o_dsc !== 1'b1) begin $display("FAIL dsc_src_dsc got=%b want=1", o_dsc); bad++; end
    dst_dsc_n = 1'b1;
    idle_src();
    @(negedge clk);
    total++; if (gnt !== 3'b001) begin $display("FAIL dsc_retry got=%b want=001", gnt); bad++; end
    total++; if (abort !== 3'b000) begin $display("FAIL dsc_pulse got=%b want=000", abort); bad++; end
    drive(0, 1'b1, 1'b0, 64'h1111);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'h2222);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'h3333);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 64'h4444);
    req = 3'b000;
    @(negedge clk);
    total++; if (gnt !== 3'b000) begin $display("FAIL dsc_eof_drop got=%b want=000", gnt); bad++; end
    total++; if (abort !== 3'b000) begin $display("FAIL dsc_eof_abort got=%b want=000", abort); bad++; end
    idle_src();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 3'b001;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 64'hAAAA);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'hBBBB);
    #1;
    total++; if (o_rdy !== 1'b0) begin $display("FAIL ar_pre_rdy got=%b want=0", o_rdy); bad++; end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (gnt !== 3'b000) begin $display("FAIL ar_gnt got=%b want=000", gnt); bad++; end
    total++; if (o_rdy !== 1'b1) begin $display("FAIL ar_rdy got=%b want=1", o_rdy); bad++; end
    @(negedge clk);
    req = 3'b000;
    idle_src();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_buf_av();
    test_timeout();
    test_discontinue();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
